seg_write_arbiter: RTL and testbench

Shares the write port (write/sel/num) of the 8-digit seven-segment display register file between NUM_REQ independent requesters. Each requester asks to update a whole 8-digit frame (32-bit word plus 8-bit digit mask); the block arbitrates, latches the winner's frame, then sequences eight single-digit write cycles into the display block before signalling completion. It sits directly upstream of the display block, on the same clock.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_write_arbiter_rr_arbiter.sv | 46 ++++
 rtl/seg_write_arbiter.sv | 115 +++++++++++
 tb/tb_seg_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and sizes for the seven-segment write arbiter.
// Digit geometry of the 8-digit display frame.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 3;
  localparam int FRAME_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/seg_write_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from a pointer, or
// fixed lowest-index priority when SEG_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

`ifdef SEG_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Scan downward so the lowest set bit is the last one kept.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = PW'(i);
      end
    end
  end
`else
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!found && req_i[(int'(ptr_i) + o) % N]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_i) + o) % N] = 1'b1;
        idx_o = PW'((int'(ptr_i) + o) % N);
      end
    end
  end
`endif

endmodule

// File: rtl/seg_write_arbiter.sv
// Arbitrates whole-frame updates onto the display write port.
// SEG_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module seg_write_arbiter
  import seg_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_data,
  input  logic [NUM_REQ*8-1:0]    req_mask,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic                    write,
  output logic [SEL_W-1:0]        sel,
  output logic [DIGIT_W-1:0]      num
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    data_q, data_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0]    win_q, win_d;
  logic [PW-1:0]         ptr;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PW-1:0]         arb_idx;

`ifdef SEG_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req) begin
      ptr_d = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = WRITE;
          idx_d   = '0;
          data_d  = req_data[FRAME_W*arb_idx +: FRAME_W];
          mask_d  = req_mask[NUM_DIGITS*arb_idx +: NUM_DIGITS];
          win_d   = arb_gnt;
        end
      end
      WRITE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == SEL_W'(NUM_DIGITS - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        win_d   = '0;
      end
      default: begin
        state_d = IDLE;
        win_d   = '0;
      end
    endcase
  end

  // All outputs come from registered state only.
  logic in_write;
  assign in_write = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign gnt      = win_q;
  assign done     = (state_q == DONE) ? win_q : '0;
  assign write    = in_write & mask_q[idx_q];
  assign sel      = in_write ? idx_q : '0;
  assign num      = in_write ? data_q[DIGIT_W*idx_q +: DIGIT_W] : '0;

endmodule

// File: tb/tb_seg_write_arbiter.sv
// Directed self-checking bench for seg_write_arbiter.
// Includes a tiny display register file fed by write/sel/num.
module tb_seg_write_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*32-1:0] req_data;
  logic [NR*8-1:0] req_mask;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic            busy;
  logic            write;
  logic [2:0]      sel;
  logic [3:0]      num;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] disp [8];

  seg_write_arbiter #(.NUM_REQ(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_mask (req_mask),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .write    (write),
    .sel      (sel),
    .num      (num)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write) disp[sel] <= num;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    req_mask = '0;
    #3;
    n_cmp++;
    if ({gnt, done, busy, write, sel, num} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want 0000",
               {gnt, done, busy, write, sel, num});
    end
    step();
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if ({gnt, busy} !== 5'h0) begin
      n_err++;
      $display("FAIL idle_no_req: got %h want 00", {gnt, busy});
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) disp[i] = 4'hx;
    req = 4'b0001;
    req_data[31:0] = 32'h76543210;
    req_mask[7:0]  = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || sel !== 3'(i) ||
          num !== 4'(i) || write !== 1'b1 || done !== 4'b0) begin
        n_err++;
        $display("FAIL single_w%0d: got gnt=%b busy=%b sel=%0d num=%h wr=%b done=%b want 0001 1 %0d %0h 1 0000",
                 i, gnt, busy, sel, num, write, done, i, i);
      end
      step();
    end
    n_cmp++;
    if (done !== 4'b0001 || gnt !== 4'b0001 || write !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got done=%b gnt=%b wr=%b busy=%b want 0001 0001 0 1",
               done, gnt, write, busy);
    end
    req = '0;
    step();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
      n_err++;
      $display("FAIL single_idle: got gnt=%b busy=%b done=%b want 0000 0 0000",
               gnt, busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (disp[i] !== 4'(i)) begin
        n_err++;
        $display("FAIL disp_%0d: got %h want %h", i, disp[i], 4'(i));
      end
    end
  endtask

  task automatic test_mask();
    req = 4'b0010;
    req_data[63:32] = 32'hFFFFFFFF;
    req_mask[15:8]  = 8'h05;
    step();
    for (int i = 0; i < 8; i++) begin
      logic exp_w;
      exp_w = (i == 0 || i == 2);
      n_cmp++;
      if (gnt !== 4'b0010 || sel !== 3'(i) || num !== 4'hF ||
          write !== exp_w || done !== 4'b0) begin
        n_err++;
        $display("FAIL mask_w%0d: got gnt=%b sel=%0d num=%h wr=%b done=%b want 0010 %0d f %b 0000",
                 i, gnt, sel, num, write, done, i, exp_w);
      end
      step();
    end
    n_cmp++;
    if (done !== 4'b0010) begin
      n_err++;
      $display("FAIL mask_done: got %b want 0010", done);
    end
    req = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [5];
`ifdef SEG_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    req_mask = '1;
    req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      n_cmp++;
      if (gnt !== exp_g[t] || sel !== 3'd0) begin
        n_err++;
        $display("FAIL rr_grant%0d: got gnt=%b sel=%0d want %b 0",
                 t, gnt, sel, exp_g[t]);
      end
      for (int c = 0; c < 9; c++) step();
      n_cmp++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rr_gap%0d: got gnt=%b busy=%b want 0000 0", t, gnt, busy);
      end
      step();
    end
    req = '0;
    for (int c = 0; c < 10; c++) step();
  endtask

  task automatic test_sample_once();
    do_reset();
    req = 4'b0100;
    req_data[95:64] = 32'hAAAAAAAA;
    req_mask[23:16] = 8'hFF;
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL samp_grant: got %b want 0100", gnt);
    end
    req = '0;
    req_data[95:64] = 32'h55555555;
    req_mask[23:16] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (num !== 4'hA || write !== 1'b1 || sel !== 3'(i)) begin
        n_err++;
        $display("FAIL samp_w%0d: got num=%h wr=%b sel=%0d want a 1 %0d",
                 i, num, write, sel, i);
      end
      step();
    end
    n_cmp++;
    if (done !== 4'b0100) begin
      n_err++;
      $display("FAIL samp_done: got %b want 0100", done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001;
    req_data[31:0] = 32'h76543210;
    req_mask[7:0]  = 8'hFF;
    req_data[127:96] = 32'h89ABCDEF;
    req_mask[31:24]  = 8'hFF;
    step();
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (sel !== 3'd4 || write !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: got sel=%0d wr=%b want 4 1", sel, write);
    end
    #2;
    reset = 1'b1;
    req = 4'b1000;
    #1;
    n_cmp++;
    if ({gnt, done, busy, write, sel, num} !== 16'h0) begin
      n_err++;
      $display("FAIL rmid_async: got %h want 0000",
               {gnt, done, busy, write, sel, num});
    end
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (write !== 1'b0 || done !== 4'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_hold%0d: got wr=%b done=%b busy=%b want 0 0000 0",
                 c, write, done, busy);
      end
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 3'd0 || num !== 4'hF || write !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_regrant: got gnt=%b sel=%0d num=%h wr=%b want 1000 0 f 1",
               gnt, sel, num, write);
    end
    for (int c = 0; c < 8; c++) step();
    n_cmp++;
    if (done !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_done: got %b want 1000", done);
    end
    req = '0;
    step();
  endtask

  task automatic test_zero_mask();
    int busy_cnt;
    int wr_cnt;
    int done_at;
    busy_cnt = 0;
    wr_cnt   = 0;
    done_at  = -1;
    req = 4'b0001;
    req_data[31:0] = 32'h12345678;
    req_mask[7:0]  = 8'h00;
    step();
    for (int c = 0; c < 10; c++) begin
      if (busy) busy_cnt++;
      if (write) wr_cnt++;
      if (done === 4'b0001) done_at = c;
      if (c == 8) req = '0;
      step();
    end
    n_cmp++;
    if (wr_cnt !== 0) begin
      n_err++;
      $display("FAIL zm_writes: got %0d want 0", wr_cnt);
    end
    n_cmp++;
    if (busy_cnt !== 9) begin
      n_err++;
      $display("FAIL zm_busy: got %0d want 9", busy_cnt);
    end
    n_cmp++;
    if (done_at !== 8) begin
      n_err++;
      $display("FAIL zm_done_at: got %0d want 8", done_at);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask();
    test_round_robin();
    test_sample_once();
    test_reset_mid();
    test_zero_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
